// File: rtl/watch_tick_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : watch_tick_ctrl_pkg
// Brief    : Mode encodings and counter sizing helper for the watch tick block.
// Revision : 1.0
// ============================================================================
package watch_tick_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_MIN  = 2'd1,
        MODE_SET_HOUR = 2'd2,
        MODE_UNUSED   = 2'd3
    } mode_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/watch_tick_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Synchronise and debounce one active-low key, flag debounced presses.
// Revision : 1.0
// ============================================================================
module key_debounce
    import watch_tick_ctrl_pkg::*;
#(
    parameter int DB_CNT = 1000000
) (
    input  logic clk,
    input  logic nreset,
    input  logic key_n,
    output logic pressed,
    output logic level_n
);

    localparam int                 c_cnt_w    = cnt_w(DB_CNT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CNT - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_pressed;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_pressed <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= key_n;
            r_sync2   <= r_sync1;
            r_pressed <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                // Only a 1->0 acceptance is a press; release is silent.
                r_level   <= r_sync2;
                r_pressed <= ~r_sync2;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pressed = r_pressed;
    assign level_n = r_level;

endmodule
`default_nettype wire

// File: rtl/watch_tick_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : watch_tick_ctrl
// Brief    : Seconds prescaler, key debounce, RUN/SET mode FSM, set increments
//            with auto-repeat and field blink for the DigitalWatch counters.
// Revision : 1.0
// ============================================================================
module watch_tick_ctrl
    import watch_tick_ctrl_pkg::*;
#(
    parameter int DIV     = 50000000,
    parameter int DB_CNT  = 1000000,
    parameter int RPT_DLY = 25000000,
    parameter int RPT_PER = 5000000
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic       sec_cin,
    output logic       min_set,
    output logic       hour_set,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int                 c_pre_w    = cnt_w(DIV);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(DIV - 1);
    localparam int                 c_blk_half = (DIV / 4 > 0) ? (DIV / 4) : 1;
    localparam int                 c_blk_w    = cnt_w(c_blk_half);
    localparam logic [c_blk_w-1:0] c_blk_last = c_blk_w'(c_blk_half - 1);
    localparam int                 c_rpt_max  = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int                 c_rpt_w    = cnt_w(c_rpt_max);
    localparam logic [c_rpt_w-1:0] c_dly_last = c_rpt_w'(RPT_DLY - 1);
    localparam logic [c_rpt_w-1:0] c_per_last = c_rpt_w'(RPT_PER - 1);

    // Index 0 is the mode key, index 1 the increment key.
    logic [1:0] w_key_raw;
    logic [1:0] w_press;
    logic [1:0] w_level_n;
    logic       w_unused_mode_lvl;

    assign w_key_raw         = {key_inc, key_mode};
    assign w_unused_mode_lvl = w_level_n[0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        key_debounce #(
            .DB_CNT (DB_CNT)
        ) u_key_debounce (
            .clk     (clk),
            .nreset  (nreset),
            .key_n   (w_key_raw[gi]),
            .pressed (w_press[gi]),
            .level_n (w_level_n[gi])
        );
    end

    mode_t r_mode;
    mode_t w_mode_nxt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_mode <= MODE_RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        unique case (r_mode)
            MODE_RUN:      if (w_press[0]) w_mode_nxt = MODE_SET_MIN;
            MODE_SET_MIN:  if (w_press[0]) w_mode_nxt = MODE_SET_HOUR;
            MODE_SET_HOUR: if (w_press[0]) w_mode_nxt = MODE_RUN;
            default:       w_mode_nxt = MODE_RUN;
        endcase
    end

    // Prescaler: counts only while RUN persists, so a return to RUN restarts from 0.
    logic [c_pre_w-1:0] r_pre_cnt;
    logic [c_pre_w-1:0] w_pre_nxt;
    logic               w_run_stay;
    logic               r_sec;

    assign w_run_stay = (r_mode == MODE_RUN) && (w_mode_nxt == MODE_RUN);
    assign w_pre_nxt  = (r_pre_cnt == c_pre_last) ? '0 : r_pre_cnt + 1'b1;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pre_cnt <= '0;
            r_sec     <= 1'b0;
        end else if (w_run_stay) begin
            r_pre_cnt <= w_pre_nxt;
            r_sec     <= (w_pre_nxt == c_pre_last);
        end else begin
            r_pre_cnt <= '0;
            r_sec     <= 1'b0;
        end
    end

    logic [c_blk_w-1:0] r_blk_cnt;
    logic               r_blink;
    logic               w_set_entry;

    assign w_set_entry = (w_mode_nxt != r_mode) && (w_mode_nxt != MODE_RUN);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_blk_cnt <= '0;
            r_blink   <= 1'b1;
        end else if ((w_mode_nxt == MODE_RUN) || w_set_entry) begin
            r_blk_cnt <= '0;
            r_blink   <= 1'b1;
        end else if (r_blk_cnt == c_blk_last) begin
            r_blk_cnt <= '0;
            r_blink   <= ~r_blink;
        end else begin
            r_blk_cnt <= r_blk_cnt + 1'b1;
        end
    end

    // Increment pulses: a mode press always wins and disarms repeat until a fresh inc press.
    logic [c_rpt_w-1:0] r_rpt_cnt;
    logic               r_rpt_en;
    logic               r_rpt_first;
    logic               r_min;
    logic               r_hour;
    logic               w_in_set;
    logic               w_rpt_fire;

    assign w_in_set   = (r_mode == MODE_SET_MIN) || (r_mode == MODE_SET_HOUR);
    assign w_rpt_fire = r_rpt_first ? (r_rpt_cnt == c_dly_last) : (r_rpt_cnt == c_per_last);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rpt_cnt   <= '0;
            r_rpt_en    <= 1'b0;
            r_rpt_first <= 1'b0;
            r_min       <= 1'b0;
            r_hour      <= 1'b0;
        end else begin
            r_min  <= 1'b0;
            r_hour <= 1'b0;
            if (w_press[0]) begin
                r_rpt_en    <= 1'b0;
                r_rpt_first <= 1'b0;
                r_rpt_cnt   <= '0;
            end else if (w_press[1]) begin
                r_min       <= (r_mode == MODE_SET_MIN);
                r_hour      <= (r_mode == MODE_SET_HOUR);
                r_rpt_en    <= w_in_set;
                r_rpt_first <= 1'b1;
                r_rpt_cnt   <= '0;
            end else if (r_rpt_en) begin
                if (w_level_n[1]) begin
                    r_rpt_en  <= 1'b0;
                    r_rpt_cnt <= '0;
                end else if (w_rpt_fire) begin
                    r_min       <= (r_mode == MODE_SET_MIN);
                    r_hour      <= (r_mode == MODE_SET_HOUR);
                    r_rpt_first <= 1'b0;
                    r_rpt_cnt   <= '0;
                end else begin
                    r_rpt_cnt <= r_rpt_cnt + 1'b1;
                end
            end
        end
    end

    assign sec_cin  = r_sec;
    assign min_set  = r_min;
    assign hour_set = r_hour;
    assign mode     = r_mode;
    assign blink    = r_blink;

endmodule
`default_nettype wire
